std_gray_ptr_sync: RTL and testbench
====================================

// Module: std_gray_ptr_sync
// PURPOSE
//   Destination-domain stage that consumes the Gray-encoded pointer produced by std_gray_encoder
//   in another clock domain. It synchronises the pointer through a flop chain, decodes it to
//   binary and reports each change as a one-cycle update with a binary delta. It flags any
//   non-Gray step (more than one bit changed between consecutive samples) as a sticky error.
//   Used on async FIFO read/write pointer crossings.
// PARAMETERS
//   WIDTH   8   pointer width in bits, >= 2
//   STAGES  2   synchroniser flop count, >= 2
// PORTS
//   i_clk        input   1      destination clock
//   i_rst        input   1      synchronous active-high reset
//   i_gray       input   WIDTH  Gray pointer from foreign domain (asynchronous, unregistered here)
//   i_clear_err  input   1      clears o_err (synchronous)
//   o_gray_sync  output  WIDTH  last synchronised Gray sample (chain output)
//   o_bin        output  WIDTH  registered binary decode of o_gray_sync
//   o_delta      output  WIDTH  (new o_bin - previous o_bin) mod 2^WIDTH, held between updates
//   o_update     output  1      one-cycle pulse when o_bin takes a new value in RUN
//   o_err        output  1      sticky: a synchronised sample differed from prior in >1 bit
//   o_ready      output  1      high once state == RUN
// BEHAVIOUR
//   - Reset (i_rst=1 at posedge): all sync flops, o_bin, o_delta, o_update, o_err, o_ready = 0;
//     fill counter = 0; state = INIT. Reset has priority over all other inputs.
//   - Sync chain: sync[0] <= i_gray; sync[k] <= sync[k-1]; o_gray_sync = sync[STAGES-1].
//     No logic between chain flops.
//   - Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. Registered into o_bin.
//   - FSM:
//     INIT: fill counter increments each cycle. At count STAGES-1 -> PRIME.
//       o_update, o_err unchanged (0).
//     PRIME: one cycle. o_bin <= decode(o_gray_sync); prev_gray <= o_gray_sync;
//       o_delta stays 0; no o_update, no error check. -> RUN.
//     RUN: every cycle, prev_gray <= o_gray_sync and o_bin <= decode(o_gray_sync).
//       If o_gray_sync != prev_gray: o_update = 1 for that cycle.
//       o_delta <= decode(o_gray_sync) - o_bin, computed mod 2^WIDTH with wrap.
//       o_update rises in the same cycle that o_bin changes.
//       If popcount(o_gray_sync ^ prev_gray) > 1: o_err <= 1.
//       The update and delta still occur; the pointer is never held back.
//     o_ready = (state == RUN).
//   - Latency: a stable change on i_gray reaches o_gray_sync after STAGES edges. It reaches
//     o_bin / o_update / o_err one edge later (STAGES+1 total).
//   - o_err clear: i_clear_err=1 clears o_err next edge. A simultaneous set wins over clear.
//   - Wrap-around: pointer from 2^WIDTH-1 to 0 is a legal 1-bit Gray step. o_delta = 1, no error.
//   - Multi-step jumps (source advanced twice between destination samples) are legal when each
//     sampled step is Gray-legal. o_delta then carries the full binary difference.
//   - Reset mid-operation: returns to INIT. The first post-reset value is absorbed in PRIME
//     without o_update or o_err.
//   - Gray/binary arithmetic is unsigned, WIDTH bits, no sign or overflow flags.
// TESTING
//   1 Reset/prime: WIDTH=8, STAGES=2, i_gray=8'h0F held, deassert i_rst ->
//     o_ready=1 after 3 clocks, o_bin=8'h0A, o_update never pulsed, o_delta=0, o_err=0.
//   2 Single step: in RUN with o_bin=5, drive i_gray=gray(6)=8'h05 ->
//     exactly STAGES+1 clocks later o_update=1 for one cycle, o_bin=6, o_delta=1, o_err=0.
//   3 Wrap: o_bin=255 (i_gray=8'h80), drive i_gray=8'h00 -> o_bin=0, o_delta=1, o_update pulse,
//     o_err=0.
//   4 Illegal step: o_bin=0 (i_gray=8'h00), drive i_gray=8'h03 -> o_update=1, o_bin=2,
//     o_delta=2, o_err=1 and stays 1.
//     Then i_clear_err=1 with no new violation -> o_err=0.
//     Clear coinciding with a new violation -> o_err stays 1.
//   5 Reset mid-run: o_bin=0x40, assert i_rst one cycle while i_gray=gray(0x41) ->
//     outputs zero, o_ready=0 for STAGES+1 clocks, then o_bin=0x41 with no o_update/o_err.
//   6 Exhaustive walk: source counts 0..2^WIDTH*2 through gray(x), one step every 3 clocks ->
//     o_bin tracks x with STAGES+1 lag, every o_delta=1, o_err never set.

Source files
------------

// File: rtl/std_gray_ptr_sync.sv
// Destination-domain Gray pointer synchroniser: flop chain, binary decode, per-change delta
// reporting and a sticky flag for any sampled step that is not a single-bit Gray step.
module std_gray_ptr_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_gray_sync,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_update,
  output logic             o_err,
  output logic             o_ready
);

  typedef enum logic [1:0] {INIT, PRIME, RUN} state_t;

  localparam int CNT_W = $clog2(STAGES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fill_cnt;
  logic             prime_en, run_en;

  logic [WIDTH-1:0] sync_p0 [STAGES];
  logic [WIDTH-1:0] prev_gray_p1;
  logic [WIDTH-1:0] dec_bin;
  logic             changed, multi_bit;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Non-zero after clearing the lowest set bit means at least two bits differ.
  function automatic logic more_than_one_bit(input logic [WIDTH-1:0] x);
    return (x & (x - 1'b1)) != '0;
  endfunction

  // Stage p0: synchroniser chain, no logic between flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= i_gray;
      for (int k = 1; k < STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign o_gray_sync = sync_p0[STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (fill_cnt == CNT_W'(STAGES - 1)) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    prime_en = (state == PRIME);
    run_en   = (state == RUN);
    o_ready  = (state == RUN);
  end

  assign dec_bin   = gray_to_bin(o_gray_sync);
  assign changed   = (o_gray_sync != prev_gray_p1);
  assign multi_bit = more_than_one_bit(o_gray_sync ^ prev_gray_p1);

  // Stage p1: previous Gray sample, reloaded by PRIME before it is ever compared
  always_ff @(posedge i_clk) begin
    if (prime_en || run_en) prev_gray_p1 <= o_gray_sync;
  end

  // Stage p1: decoded pointer, delta, update strobe and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bin    <= '0;
      o_delta  <= '0;
      o_update <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_update <= run_en && changed;
      if (prime_en || run_en) o_bin <= dec_bin;
      if (run_en && changed) o_delta <= dec_bin - o_bin;
      if (run_en && multi_bit) o_err <= 1'b1;
      else if (i_clear_err)    o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_std_gray_ptr_sync.sv
// Bench for std_gray_ptr_sync: directed scenarios plus random pointer traffic, every cycle
// compared against a cycle-count/queue reference model of the pointer crossing.
module tb_std_gray_ptr_sync;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic         clear_err = 1'b0;
  logic [W-1:0] gray_sync, bin, delta;
  logic         update, err, ready;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state
  logic [W-1:0] pipe [$];
  int           since_rst;
  logic [W-1:0] m_bin, m_delta, m_prev, m_sync;
  logic         m_upd, m_err, m_ready;

  std_gray_ptr_sync #(.WIDTH(W), .STAGES(S)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_gray      (gray_in),
    .i_clear_err (clear_err),
    .o_gray_sync (gray_sync),
    .o_bin       (bin),
    .o_delta     (delta),
    .o_update    (update),
    .o_err       (err),
    .o_ready     (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray_of(input int v);
    logic [W-1:0] x;
    x = W'(v);
    return x ^ (x >> 1);
  endfunction

  // inverse Gray by search: the value whose Gray code matches
  function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
    for (int v = 0; v < (1 << W); v++)
      if (gray_of(v) == g) return W'(v);
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] g, input logic clr, input logic r);
    logic [W-1:0] old_sync, nb;
    if (r) begin
      pipe = {};
      for (int i = 0; i < S; i++) pipe.push_back('0);
      since_rst = 0;
      m_bin = '0; m_delta = '0; m_upd = 1'b0; m_err = 1'b0; m_ready = 1'b0;
    end else begin
      old_sync = pipe[S-1];
      pipe.push_front(g);
      void'(pipe.pop_back());
      since_rst++;
      m_upd = 1'b0;
      if (since_rst == S + 1) begin
        m_bin  = bin_of(old_sync);
        m_prev = old_sync;
        if (clr) m_err = 1'b0;
      end else if (since_rst > S + 1) begin
        nb = bin_of(old_sync);
        if (old_sync != m_prev) begin
          m_upd   = 1'b1;
          m_delta = nb - m_bin;
        end
        if ($countones(old_sync ^ m_prev) > 1) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_bin  = nb;
        m_prev = old_sync;
      end else if (clr) begin
        m_err = 1'b0;
      end
      m_ready = (since_rst >= S + 1);
    end
    m_sync = pipe[S-1];
  endtask

  task automatic step(input logic [W-1:0] g, input logic clr, input logic r);
    @(negedge clk);
    gray_in = g; clear_err = clr; rst = r;
    @(posedge clk);
    model_edge(g, clr, r);
    #1;
    check("gray_sync", 32'(gray_sync), 32'(m_sync));
    check("bin",       32'(bin),       32'(m_bin));
    check("delta",     32'(delta),     32'(m_delta));
    check("update",    32'(update),    32'(m_upd));
    check("err",       32'(err),       32'(m_err));
    check("ready",     32'(ready),     32'(m_ready));
  endtask

  task automatic hold(input logic [W-1:0] g, input int n);
    for (int i = 0; i < n; i++) step(g, 1'b0, 1'b0);
  endtask

  initial begin
    int x;
    int upd_seen;

    // 1: reset and prime with 0x0F held
    step(8'h0F, 1'b0, 1'b1);
    check("t1_rst_ready", 32'(ready), 0);
    check("t1_rst_bin", 32'(bin), 0);
    upd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'h0F, 1'b0, 1'b0);
      if (update) upd_seen++;
      if (i < 2) check("t1_not_ready", 32'(ready), 0);
    end
    check("t1_ready", 32'(ready), 1);
    check("t1_bin", 32'(bin), 32'h0A);
    check("t1_delta", 32'(delta), 0);
    check("t1_err", 32'(err), 0);
    check("t1_no_update", 32'(upd_seen), 0);
    hold(8'h0F, 2);

    // 2: single step 5 -> 6
    hold(gray_of(5), 4);
    check("t2_bin5", 32'(bin), 5);
    step(gray_of(6), 1'b0, 1'b0);
    check("t2_upd_lat1", 32'(update), 0);
    step(gray_of(6), 1'b0, 1'b0);
    check("t2_upd_lat2", 32'(update), 0);
    step(gray_of(6), 1'b0, 1'b0);
    check("t2_upd", 32'(update), 1);
    check("t2_bin6", 32'(bin), 6);
    check("t2_delta", 32'(delta), 1);
    step(gray_of(6), 1'b0, 1'b0);
    check("t2_upd_once", 32'(update), 0);
    check("t2_delta_held", 32'(delta), 1);
    check("t2_err", 32'(err), 0);

    // 3: wrap 255 -> 0 (0x80 -> 0x00); walk up to 255 legally first
    for (int v = 7; v <= 255; v++) step(gray_of(v), 1'b0, 1'b0);
    hold(8'h80, 3);
    check("t3_bin255", 32'(bin), 255);
    hold(8'h00, 3);
    check("t3_upd", 32'(update), 1);
    check("t3_bin0", 32'(bin), 0);
    check("t3_delta", 32'(delta), 1);
    check("t3_err", 32'(err), 0);

    // 4: illegal step 0x00 -> 0x03, sticky, clear, clear colliding with new violation
    hold(8'h00, 2);
    hold(8'h03, 3);
    check("t4_upd", 32'(update), 1);
    check("t4_bin", 32'(bin), 2);
    check("t4_delta", 32'(delta), 2);
    check("t4_err", 32'(err), 1);
    hold(8'h03, 4);
    check("t4_err_sticky", 32'(err), 1);
    step(8'h03, 1'b1, 1'b0);
    check("t4_err_cleared", 32'(err), 0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0);
    check("t4_set_beats_clear", 32'(err), 1);
    hold(8'h00, 2);
    check("t4_err_held", 32'(err), 1);

    // 5: reset mid-run with gray(0x41) on the input
    step(gray_of(8'h3F), 1'b1, 1'b0);
    step(gray_of(8'h40), 1'b0, 1'b0);
    hold(gray_of(8'h40), 3);
    check("t5_bin40", 32'(bin), 32'h40);
    upd_seen = 0;
    step(gray_of(8'h41), 1'b0, 1'b1);
    check("t5_rst_bin", 32'(bin), 0);
    check("t5_rst_err", 32'(err), 0);
    check("t5_rst_sync", 32'(gray_sync), 0);
    for (int i = 0; i < 3; i++) begin
      check("t5_not_ready", 32'(ready), 0);
      step(gray_of(8'h41), 1'b0, 1'b0);
      if (update || err) upd_seen++;
    end
    check("t5_ready", 32'(ready), 1);
    check("t5_bin41", 32'(bin), 32'h41);
    check("t5_quiet", 32'(upd_seen), 0);

    // 6: exhaustive walk from a fresh reset
    step(8'h00, 1'b0, 1'b1);
    hold(8'h00, 3);
    upd_seen = 0;
    for (int v = 0; v <= 2 * (1 << W); v++) begin
      for (int i = 0; i < 3; i++) begin
        step(gray_of(v), 1'b0, 1'b0);
        if (update) begin
          upd_seen++;
          check("t6_delta", 32'(delta), 1);
        end
      end
    end
    hold(gray_of(2 * (1 << W)), 3);
    check("t6_updates", 32'(upd_seen), 2 * (1 << W));
    check("t6_bin", 32'(bin), 0);
    check("t6_err", 32'(err), 0);

    // random traffic: mostly legal steps, some jumps, clears and resets
    x = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      x = x + 1;
      else if (r < 52) x = $urandom_range(0, (1 << W) - 1);
      step(gray_of(x), ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
